// File: rtl/vec_issue_pkg.sv
// Shared types, opcode constants and issue-response decode for the vector issue queue.
// Opcode and funct7 values mirror the custom-0 encodings used by the core's custom_opcodes.vh.
package vec_issue_pkg;

    localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
    localparam logic [6:0] FUNCT7_VLD     = 7'b0000001;
    localparam logic [6:0] FUNCT7_VST     = 7'b0000010;
    localparam logic [6:0] FUNCT7_VMAC    = 7'b0000011;

    // Entries store ids at this width so the struct is independent of X_ID_WIDTH.
    localparam int ID_MAX_W = 8;

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        PENDING   = 2'd1,
        COMMITTED = 2'd2,
        KILLED    = 2'd3
    } entry_state_t;

    typedef struct packed {
        entry_state_t          state;
        logic [31:0]           instr;
        logic [31:0]           rs1;
        logic [ID_MAX_W-1:0]   id;
    } viq_entry_t;

    typedef struct packed {
        logic accept;
        logic writeback;
        logic loadstore;
    } viq_resp_t;

    function automatic viq_resp_t viq_decode_fn(input logic [6:0] opcode,
                                                input logic [6:0] funct7);
        viq_resp_t r;
        logic      known;
        known       = (funct7 == FUNCT7_VLD) || (funct7 == FUNCT7_VST) ||
                      (funct7 == FUNCT7_VMAC);
        r.accept    = (opcode == OPCODE_CUSTOM0) && known;
        r.writeback = r.accept && (funct7 != FUNCT7_VST);
        r.loadstore = r.accept && ((funct7 == FUNCT7_VLD) || (funct7 == FUNCT7_VST));
        return r;
    endfunction

endpackage

// File: rtl/vec_issue_queue_decode.sv
// Combinational X-IF issue-response decode for custom-0 vector instructions.
// Shared by the issue queue and the coprocessor.
module viq_decode
    import vec_issue_pkg::*;
(
    input  logic [31:0] instr,
    output logic        accept,
    output logic        writeback,
    output logic        loadstore
);

    viq_resp_t resp;
    logic      unused_fields;

    assign resp          = viq_decode_fn(instr[6:0], instr[31:25]);
    assign accept        = resp.accept;
    assign writeback     = resp.writeback;
    assign loadstore     = resp.loadstore;
    assign unused_fields = ^instr[24:7];

endmodule

// File: rtl/vec_issue_queue.sv
// Commit-tracking issue queue between the X-IF issue/commit interfaces and the vector coprocessor.
// Optional statistics counters are enabled with `define VIQ_STATS_EN. X_ID_WIDTH must not exceed 8.
module vec_issue_queue
    import vec_issue_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int X_ID_WIDTH = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,

    input  logic                      issue_valid_i,
    output logic                      issue_ready_o,
    input  logic [31:0]               issue_instr_i,
    input  logic [31:0]               issue_rs1_i,
    input  logic [X_ID_WIDTH-1:0]     issue_id_i,
    output logic                      issue_accept_o,
    output logic                      issue_writeback_o,
    output logic                      issue_loadstore_o,

    input  logic                      commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]     commit_id_i,
    input  logic                      commit_kill_i,

    output logic                      dispatch_valid_o,
    input  logic                      dispatch_ready_i,
    output logic [6:0]                dispatch_funct7_o,
    output logic [4:0]                dispatch_rd_o,
    output logic [4:0]                dispatch_rs1_o,
    output logic [4:0]                dispatch_rs2_o,
    output logic [31:0]               dispatch_scalar_o,
    output logic [X_ID_WIDTH-1:0]     dispatch_id_o,
`ifdef VIQ_STATS_EN
    output logic [15:0]               stat_dispatched_o,
    output logic [15:0]               stat_killed_o,
`endif
    output logic [$clog2(DEPTH):0]    count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    viq_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    viq_entry_t         head_entry;
    viq_entry_t         push_entry;
    logic               full;
    logic               push;
    logic               pop_dispatch;
    logic               pop_kill;
    logic               pop;
    logic               unused_head;

    viq_decode u_decode (
        .instr     (issue_instr_i),
        .accept    (issue_accept_o),
        .writeback (issue_writeback_o),
        .loadstore (issue_loadstore_o)
    );

    assign head_entry   = entries[head];
    assign full         = (count == CNT_W'(DEPTH));
    assign issue_ready_o = !full;
    assign push         = issue_valid_i && issue_ready_o && issue_accept_o;

    // Killed heads retire silently; only one pop of either kind per cycle.
    assign dispatch_valid_o = (head_entry.state == COMMITTED);
    assign pop_dispatch     = dispatch_valid_o && dispatch_ready_i;
    assign pop_kill         = (head_entry.state == KILLED);
    assign pop              = pop_dispatch || pop_kill;

    // Popped entries are zeroed, so an EMPTY head drives all-zero dispatch fields.
    assign dispatch_funct7_o = head_entry.instr[31:25];
    assign dispatch_rs2_o    = head_entry.instr[24:20];
    assign dispatch_rs1_o    = head_entry.instr[19:15];
    assign dispatch_rd_o     = head_entry.instr[11:7];
    assign dispatch_scalar_o = head_entry.rs1;
    assign dispatch_id_o     = head_entry.id[X_ID_WIDTH-1:0];
    assign count_o           = count;
    assign unused_head       = ^{head_entry.instr[14:12], head_entry.instr[6:0], head_entry.id};

    // A commit aimed at the instruction being pushed lands directly in the new entry.
    always_comb begin
        push_entry       = '0;
        push_entry.instr = issue_instr_i;
        push_entry.rs1   = issue_rs1_i;
        push_entry.id    = ID_MAX_W'(issue_id_i);
        push_entry.state = PENDING;
        if (commit_valid_i && (commit_id_i == issue_id_i)) begin
            push_entry.state = commit_kill_i ? KILLED : COMMITTED;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && (entries[i].state == PENDING) &&
                    (entries[i].id == ID_MAX_W'(commit_id_i))) begin
                    entries[i].state <= commit_kill_i ? KILLED : COMMITTED;
                end
            end
            if (pop) begin
                entries[head] <= '0;
                head          <= head + 1'b1;
            end
            if (push) begin
                entries[tail] <= push_entry;
                tail          <= tail + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef VIQ_STATS_EN
    logic [15:0] stat_dispatched;
    logic [15:0] stat_killed;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_dispatched <= '0;
            stat_killed     <= '0;
        end else begin
            if (pop_dispatch && (stat_dispatched != 16'hFFFF)) begin
                stat_dispatched <= stat_dispatched + 16'd1;
            end
            if (pop_kill && (stat_killed != 16'hFFFF)) begin
                stat_killed <= stat_killed + 16'd1;
            end
        end
    end

    assign stat_dispatched_o = stat_dispatched;
    assign stat_killed_o     = stat_killed;
`endif

endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed self-checking bench for vec_issue_queue (DEPTH=4, X_ID_WIDTH=4).
module tb_vec_issue_queue;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [31:0] issue_instr_i;
    logic [31:0] issue_rs1_i;
    logic [3:0]  issue_id_i;
    logic        issue_accept_o;
    logic        issue_writeback_o;
    logic        issue_loadstore_o;
    logic        commit_valid_i;
    logic [3:0]  commit_id_i;
    logic        commit_kill_i;
    logic        dispatch_valid_o;
    logic        dispatch_ready_i;
    logic [6:0]  dispatch_funct7_o;
    logic [4:0]  dispatch_rd_o;
    logic [4:0]  dispatch_rs1_o;
    logic [4:0]  dispatch_rs2_o;
    logic [31:0] dispatch_scalar_o;
    logic [3:0]  dispatch_id_o;
    logic [2:0]  count_o;
`ifdef VIQ_STATS_EN
    logic [15:0] stat_dispatched_o;
    logic [15:0] stat_killed_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    vec_issue_queue #(.DEPTH(4), .X_ID_WIDTH(4)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .issue_valid_i     (issue_valid_i),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr_i),
        .issue_rs1_i       (issue_rs1_i),
        .issue_id_i        (issue_id_i),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .issue_loadstore_o (issue_loadstore_o),
        .commit_valid_i    (commit_valid_i),
        .commit_id_i       (commit_id_i),
        .commit_kill_i     (commit_kill_i),
        .dispatch_valid_o  (dispatch_valid_o),
        .dispatch_ready_i  (dispatch_ready_i),
        .dispatch_funct7_o (dispatch_funct7_o),
        .dispatch_rd_o     (dispatch_rd_o),
        .dispatch_rs1_o    (dispatch_rs1_o),
        .dispatch_rs2_o    (dispatch_rs2_o),
        .dispatch_scalar_o (dispatch_scalar_o),
        .dispatch_id_o     (dispatch_id_o),
`ifdef VIQ_STATS_EN
        .stat_dispatched_o (stat_dispatched_o),
        .stat_killed_o     (stat_killed_o),
`endif
        .count_o           (count_o)
    );

    // Custom-0 opcode is 7'b0001011; funct7 VLD=1, VST=2, VMAC=3.
    function automatic logic [31:0] mk_instr(input logic [6:0] f7, input logic [4:0] rs2,
                                             input logic [4:0] rs1, input logic [4:0] rd,
                                             input logic [6:0] opc);
        return {f7, rs2, rs1, 3'b000, rd, opc};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid_i    = 1'b0;
        issue_instr_i    = 32'h0;
        issue_rs1_i      = 32'h0;
        issue_id_i       = 4'h0;
        commit_valid_i   = 1'b0;
        commit_id_i      = 4'h0;
        commit_kill_i    = 1'b0;
        dispatch_ready_i = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] rs1v,
                            input logic [3:0] id);
        issue_valid_i = 1'b1;
        issue_instr_i = instr;
        issue_rs1_i   = rs1v;
        issue_id_i    = id;
        tick();
        clear_inputs();
    endtask

    task automatic commit_one(input logic [3:0] id, input logic kill);
        commit_valid_i = 1'b1;
        commit_id_i    = id;
        commit_kill_i  = kill;
        tick();
        clear_inputs();
    endtask

    task automatic pop_one();
        dispatch_ready_i = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if (issue_ready_o !== 1'b1) begin
            failures++; $display("[TB] FAIL reset_ready got=%0b exp=1", issue_ready_o);
        end
        checks++;
        if (dispatch_valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reset_dvalid got=%0b exp=0", dispatch_valid_o);
        end
        checks++;
        if (count_o !== 3'd0) begin
            failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count_o);
        end
        checks++;
        if ({dispatch_funct7_o, dispatch_rd_o, dispatch_rs1_o, dispatch_rs2_o,
             dispatch_scalar_o, dispatch_id_o} !== 63'h0) begin
            failures++; $display("[TB] FAIL reset_fields got=%h/%h exp=0", dispatch_scalar_o, dispatch_id_o);
        end
    endtask

    task automatic test_push_commit_same_cycle();
        issue_valid_i  = 1'b1;
        issue_instr_i  = mk_instr(7'h01, 5'd7, 5'd6, 5'd5, 7'b0001011);
        issue_rs1_i    = 32'hDEADBEEF;
        issue_id_i     = 4'd3;
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd3;
        tick();
        clear_inputs();
        checks++;
        if (dispatch_valid_o !== 1'b1 || dispatch_id_o !== 4'd3) begin
            failures++; $display("[TB] FAIL same_cycle_dispatch got=%0b/%0d exp=1/3", dispatch_valid_o, dispatch_id_o);
        end
        checks++;
        if (count_o !== 3'd1) begin
            failures++; $display("[TB] FAIL same_cycle_count got=%0d exp=1", count_o);
        end
        checks++;
        if (dispatch_funct7_o !== 7'h01 || dispatch_rd_o !== 5'd5 ||
            dispatch_rs1_o !== 5'd6 || dispatch_rs2_o !== 5'd7) begin
            failures++; $display("[TB] FAIL fields got=%h/%0d/%0d/%0d exp=01/5/6/7", dispatch_funct7_o, dispatch_rd_o, dispatch_rs1_o, dispatch_rs2_o);
        end
        checks++;
        if (dispatch_scalar_o !== 32'hDEADBEEF) begin
            failures++; $display("[TB] FAIL scalar got=%h exp=deadbeef", dispatch_scalar_o);
        end
        pop_one();
        checks++;
        if (count_o !== 3'd0 || dispatch_valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL pop_empty got=%0d/%0b exp=0/0", count_o, dispatch_valid_o);
        end
    endtask

    task automatic test_fill_and_order();
        push_one(mk_instr(7'h03, 5'd1, 5'd2, 5'd3, 7'b0001011), 32'h11, 4'd1);
        push_one(mk_instr(7'h01, 5'd4, 5'd5, 5'd6, 7'b0001011), 32'h22, 4'd2);
        push_one(mk_instr(7'h02, 5'd7, 5'd8, 5'd9, 7'b0001011), 32'h33, 4'd3);
        push_one(mk_instr(7'h03, 5'd10, 5'd11, 5'd12, 7'b0001011), 32'h44, 4'd4);
        checks++;
        if (issue_ready_o !== 1'b0 || dispatch_valid_o !== 1'b0 || count_o !== 3'd4) begin
            failures++; $display("[TB] FAIL full_state got=%0b/%0b/%0d exp=0/0/4", issue_ready_o, dispatch_valid_o, count_o);
        end
        commit_one(4'd1, 1'b0);
        checks++;
        if (dispatch_valid_o !== 1'b1 || dispatch_id_o !== 4'd1 || dispatch_scalar_o !== 32'h11) begin
            failures++; $display("[TB] FAIL commit_head got=%0b/%0d/%h exp=1/1/11", dispatch_valid_o, dispatch_id_o, dispatch_scalar_o);
        end
        issue_valid_i    = 1'b1;
        issue_instr_i    = mk_instr(7'h01, 5'd0, 5'd0, 5'd0, 7'b0001011);
        issue_id_i       = 4'd9;
        dispatch_ready_i = 1'b1;
        #1;
        checks++;
        if (issue_ready_o !== 1'b0) begin
            failures++; $display("[TB] FAIL no_push_through got=%0b exp=0", issue_ready_o);
        end
        tick();
        clear_inputs();
        checks++;
        if (count_o !== 3'd3 || dispatch_valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL pop_from_full got=%0d/%0b exp=3/0", count_o, dispatch_valid_o);
        end
        commit_one(4'd3, 1'b0);
        checks++;
        if (dispatch_valid_o !== 1'b0) begin
            failures++; $display("[TB] FAIL out_of_order_hold got=%0b exp=0", dispatch_valid_o);
        end
        commit_one(4'd2, 1'b0);
        checks++;
        if (dispatch_valid_o !== 1'b1 || dispatch_id_o !== 4'd2 || dispatch_funct7_o !== 7'h01) begin
            failures++; $display("[TB] FAIL order_id2 got=%0b/%0d/%h exp=1/2/01", dispatch_valid_o, dispatch_id_o, dispatch_funct7_o);
        end
        pop_one();
        checks++;
        if (dispatch_valid_o !== 1'b1 || dispatch_id_o !== 4'd3 || dispatch_rd_o !== 5'd9 || count_o !== 3'd2) begin
            failures++; $display("[TB] FAIL order_id3 got=%0b/%0d/%0d/%0d exp=1/3/9/2", dispatch_valid_o, dispatch_id_o, dispatch_rd_o, count_o);
        end
        pop_one();
        checks++;
        if (dispatch_valid_o !== 1'b0 || count_o !== 3'd1) begin
            failures++; $display("[TB] FAIL pending_id4 got=%0b/%0d exp=0/1", dispatch_valid_o, count_o);
        end
        commit_one(4'd4, 1'b0);
        pop_one();
        checks++;
        if (count_o !== 3'd0) begin
            failures++; $display("[TB] FAIL drain got=%0d exp=0", count_o);
        end
    endtask

    task automatic test_kill();
        push_one(mk_instr(7'h01, 5'd1, 5'd1, 5'd1, 7'b0001011), 32'h55, 4'd5);
        push_one(mk_instr(7'h03, 5'd2, 5'd2, 5'd2, 7'b0001011), 32'h66, 4'd6);
        commit_one(4'd5, 1'b1);
        checks++;
        if (dispatch_valid_o !== 1'b0 || count_o !== 3'd2) begin
            failures++; $display("[TB] FAIL killed_head got=%0b/%0d exp=0/2", dispatch_valid_o, count_o);
        end
        commit_one(4'd6, 1'b0);
        checks++;
        if (dispatch_valid_o !== 1'b1 || dispatch_id_o !== 4'd6 || count_o !== 3'd1) begin
            failures++; $display("[TB] FAIL after_kill got=%0b/%0d/%0d exp=1/6/1", dispatch_valid_o, dispatch_id_o, count_o);
        end
        pop_one();
        issue_valid_i  = 1'b1;
        issue_instr_i  = mk_instr(7'h02, 5'd0, 5'd0, 5'd0, 7'b0001011);
        issue_id_i     = 4'd7;
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd7;
        commit_kill_i  = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if (dispatch_valid_o !== 1'b0 || count_o !== 3'd1) begin
            failures++; $display("[TB] FAIL push_kill got=%0b/%0d exp=0/1", dispatch_valid_o, count_o);
        end
        tick();
        checks++;
        if (count_o !== 3'd0) begin
            failures++; $display("[TB] FAIL silent_pop got=%0d exp=0", count_o);
        end
    endtask

    task automatic test_decode();
        issue_valid_i = 1'b1;
        issue_instr_i = mk_instr(7'h01, 5'd1, 5'd2, 5'd3, 7'b0110011);
        issue_id_i    = 4'd8;
        #1;
        checks++;
        if (issue_accept_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reject_opcode got=%0b exp=0", issue_accept_o);
        end
        tick();
        clear_inputs();
        checks++;
        if (count_o !== 3'd0) begin
            failures++; $display("[TB] FAIL reject_count got=%0d exp=0", count_o);
        end
        issue_instr_i = mk_instr(7'h10, 5'd0, 5'd0, 5'd0, 7'b0001011);
        #1;
        checks++;
        if (issue_accept_o !== 1'b0) begin
            failures++; $display("[TB] FAIL reject_funct7 got=%0b exp=0", issue_accept_o);
        end
        issue_instr_i = mk_instr(7'h02, 5'd0, 5'd0, 5'd0, 7'b0001011);
        #1;
        checks++;
        if ({issue_accept_o, issue_writeback_o, issue_loadstore_o} !== 3'b101) begin
            failures++; $display("[TB] FAIL decode_vst got=%b exp=101", {issue_accept_o, issue_writeback_o, issue_loadstore_o});
        end
        issue_instr_i = mk_instr(7'h01, 5'd0, 5'd0, 5'd0, 7'b0001011);
        #1;
        checks++;
        if ({issue_accept_o, issue_writeback_o, issue_loadstore_o} !== 3'b111) begin
            failures++; $display("[TB] FAIL decode_vld got=%b exp=111", {issue_accept_o, issue_writeback_o, issue_loadstore_o});
        end
        issue_instr_i = mk_instr(7'h03, 5'd0, 5'd0, 5'd0, 7'b0001011);
        #1;
        checks++;
        if ({issue_accept_o, issue_writeback_o, issue_loadstore_o} !== 3'b110) begin
            failures++; $display("[TB] FAIL decode_vmac got=%b exp=110", {issue_accept_o, issue_writeback_o, issue_loadstore_o});
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_stream();
        for (int i = 0; i < 4; i++) begin
            issue_valid_i  = 1'b1;
            issue_instr_i  = mk_instr(7'h03, 5'd1, 5'd2, 5'd3, 7'b0001011);
            issue_rs1_i    = 32'hA0 + i;
            issue_id_i     = 4'(10 + i);
            commit_valid_i = 1'b1;
            commit_id_i    = 4'(10 + i);
            tick();
            clear_inputs();
        end
        checks++;
        if (count_o !== 3'd4 || issue_ready_o !== 1'b0 || dispatch_valid_o !== 1'b1 || dispatch_id_o !== 4'd10) begin
            failures++; $display("[TB] FAIL full_committed got=%0d/%0b/%0b/%0d exp=4/0/1/10", count_o, issue_ready_o, dispatch_valid_o, dispatch_id_o);
        end
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        checks++;
        if (count_o !== 3'd0 || issue_ready_o !== 1'b1 || dispatch_valid_o !== 1'b0 ||
            dispatch_id_o !== 4'd0 || dispatch_scalar_o !== 32'h0) begin
            failures++; $display("[TB] FAIL mid_reset got=%0d/%0b/%0b/%0d exp=0/1/0/0", count_o, issue_ready_o, dispatch_valid_o, dispatch_id_o);
        end
`ifdef VIQ_STATS_EN
        checks++;
        if (stat_dispatched_o !== 16'd0 || stat_killed_o !== 16'd0) begin
            failures++; $display("[TB] FAIL stats_reset got=%0d/%0d exp=0/0", stat_dispatched_o, stat_killed_o);
        end
`endif
        push_one(mk_instr(7'h01, 5'd4, 5'd4, 5'd4, 7'b0001011), 32'h77, 4'd1);
        commit_one(4'd1, 1'b0);
        checks++;
        if (dispatch_valid_o !== 1'b1 || dispatch_id_o !== 4'd1 || dispatch_scalar_o !== 32'h77) begin
            failures++; $display("[TB] FAIL post_reset got=%0b/%0d/%h exp=1/1/77", dispatch_valid_o, dispatch_id_o, dispatch_scalar_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        test_reset();
        test_push_commit_same_cycle();
        test_fill_and_order();
        test_kill();
        test_decode();
        test_reset_mid_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
